// File: rtl/spi_flash_responder_if.sv
// Pad-side and memory-side signal bundle for the quad-SPI flash responder.
// The master modport is the MCU/system side (it owns sclk, cs_n, the io
// pad inputs and the backing memory's read data); the slave modport is the
// responder itself.
interface spi_flash_responder_if #(
    parameter int AWIDTH = 16
);
    logic              sclk;
    logic              cs_n;
    logic [3:0]        qdi;
    logic [3:0]        qdo;
    logic [3:0]        oe;
    logic [AWIDTH-1:0] mem_addr;
    logic              mem_rd;
    logic [7:0]        mem_data;

    modport master (
        output sclk, cs_n, qdi, mem_data,
        input  qdo, oe, mem_addr, mem_rd
    );

    modport slave (
        input  sclk, cs_n, qdi, mem_data,
        output qdo, oe, mem_addr, mem_rd
    );
endinterface

// File: rtl/spi_flash_responder.sv
// Quad-SPI NOR-flash responder (SPI mode 0). Decodes the read-class opcodes
// 03/0B/6B/EB plus 9F (JEDEC ID) and 05 (status) and streams bytes from a
// byte-wide memory read port with one-byte prefetch. sclk is oversampled in
// the clk domain; an edge is a change between the live pin and its register.
module spi_flash_responder #(
    parameter int          AWIDTH   = 16,
    parameter logic [23:0] JEDEC_ID = 24'hEF4016,
    parameter logic [7:0]  STATUS   = 8'h00,
    parameter int          QDUMMY   = 6
) (
    input  logic                 clk,
    input  logic                 arst,
    spi_flash_responder_if.slave bus
);

    typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, IGNORE} state_t;

    localparam logic [23:0] ADDR_MASK = 24'((64'd1 << AWIDTH) - 64'd1);

    state_t      r_state;
    state_t      w_stateNext;
    logic        r_sclk;
    logic [7:0]  r_cmd;
    logic [23:0] r_addr;
    logic [5:0]  r_bitCnt;
    logic [2:0]  r_outCnt;
    logic [1:0]  r_byteCnt;
    logic [7:0]  r_shift;
    logic [7:0]  r_buf;
    logic [3:0]  r_qdo;
    logic        r_memRd;
    logic        r_memRdD;

    logic        w_rise;
    logic        w_fall;
    logic [7:0]  w_cmdByte;
    logic        w_isRead;
    logic        w_isQuad;
    logic        w_quadAddr;
    logic [5:0]  w_addrLast;
    logic [5:0]  w_dummyLen;
    logic        w_enterData;
    logic [7:0]  w_nextByte;
    logic [23:0] w_addrInc;

    assign w_rise     = bus.sclk & ~r_sclk;
    assign w_fall     = ~bus.sclk & r_sclk;
    assign w_cmdByte  = {r_cmd[6:0], bus.qdi[0]};
    assign w_isRead   = (r_cmd == 8'h03) || (r_cmd == 8'h0B) ||
                        (r_cmd == 8'h6B) || (r_cmd == 8'hEB);
    assign w_isQuad   = (r_cmd == 8'h6B) || (r_cmd == 8'hEB);
    assign w_quadAddr = (r_cmd == 8'hEB);
    assign w_addrLast = w_quadAddr ? 6'd5 : 6'd23;
    assign w_dummyLen = (r_cmd == 8'hEB) ? 6'(QDUMMY) :
                        (r_cmd == 8'h03) ? 6'd0 : 6'd8;
    // Only the low AWIDTH bits count up, so the stream wraps inside the memory.
    assign w_addrInc  = ((r_addr + 24'd1) & ADDR_MASK) | (r_addr & ~ADDR_MASK);

    assign bus.oe       = (r_state == DATA) ? (w_isQuad ? 4'b1111 : 4'b0010) : 4'b0000;
    assign bus.qdo      = r_qdo;
    assign bus.mem_rd   = r_memRd;
    assign bus.mem_addr = r_addr[AWIDTH-1:0];

    // Byte to load at a byte boundary: ID/status constants, or memory data
    // taken straight off the bus when it arrives in the same cycle.
    always_comb begin
        w_nextByte = r_buf;
        if (r_cmd == 8'h9F) begin
            case (r_byteCnt)
                2'd0:    w_nextByte = JEDEC_ID[23:16];
                2'd1:    w_nextByte = JEDEC_ID[15:8];
                2'd2:    w_nextByte = JEDEC_ID[7:0];
                default: w_nextByte = 8'hFF;
            endcase
        end else if (r_cmd == 8'h05) begin
            w_nextByte = STATUS;
        end else if (r_memRdD) begin
            w_nextByte = bus.mem_data;
        end
    end

    // Next-state decode; cs_n high always returns to IDLE on the next clk.
    always_comb begin
        w_stateNext = r_state;
        w_enterData = 1'b0;
        if (bus.cs_n) begin
            w_stateNext = IDLE;
        end else begin
            case (r_state)
                IDLE: w_stateNext = CMD;
                CMD: begin
                    if (w_rise && r_bitCnt == 6'd7) begin
                        case (w_cmdByte)
                            8'h03, 8'h0B, 8'h6B, 8'hEB: w_stateNext = ADDR;
                            8'h9F, 8'h05:               w_stateNext = DATA;
                            default:                    w_stateNext = IGNORE;
                        endcase
                    end
                end
                ADDR: begin
                    if (w_rise && r_bitCnt == w_addrLast) begin
                        if (w_dummyLen == 6'd0) begin
                            w_stateNext = DATA;
                            w_enterData = 1'b1;
                        end else begin
                            w_stateNext = DUMMY;
                        end
                    end
                end
                DUMMY: begin
                    if (w_rise && r_bitCnt == (w_dummyLen - 6'd1)) begin
                        w_stateNext = DATA;
                        w_enterData = 1'b1;
                    end
                end
                default: w_stateNext = r_state;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) r_state <= IDLE;
        else      r_state <= w_stateNext;
    end

    // Shift-in of opcode/address, dummy counting, output shifter and prefetch.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_sclk    <= 1'b0;
            r_cmd     <= 8'h00;
            r_addr    <= 24'h0;
            r_bitCnt  <= 6'd0;
            r_outCnt  <= 3'd0;
            r_byteCnt <= 2'd0;
            r_shift   <= 8'h00;
            r_buf     <= 8'h00;
            r_qdo     <= 4'h0;
            r_memRd   <= 1'b0;
            r_memRdD  <= 1'b0;
        end else begin
            r_sclk   <= bus.sclk;
            r_memRd  <= 1'b0;
            r_memRdD <= r_memRd;
            if (r_memRdD) r_buf <= bus.mem_data;
            if (bus.cs_n || r_state == IDLE) begin
                r_bitCnt  <= 6'd0;
                r_outCnt  <= 3'd0;
                r_byteCnt <= 2'd0;
                r_qdo     <= 4'h0;
            end else begin
                case (r_state)
                    CMD: if (w_rise) begin
                        r_cmd    <= w_cmdByte;
                        r_bitCnt <= (r_bitCnt == 6'd7) ? 6'd0 : r_bitCnt + 6'd1;
                    end
                    ADDR: if (w_rise) begin
                        r_addr   <= w_quadAddr ? {r_addr[19:0], bus.qdi} : {r_addr[22:0], bus.qdi[0]};
                        r_bitCnt <= (r_bitCnt == w_addrLast) ? 6'd0 : r_bitCnt + 6'd1;
                    end
                    DUMMY: if (w_rise) r_bitCnt <= r_bitCnt + 6'd1;
                    DATA: if (w_fall) begin
                        if (r_outCnt == 3'd0) begin
                            if (w_isQuad) begin
                                r_qdo   <= w_nextByte[7:4];
                                r_shift <= {w_nextByte[3:0], 4'h0};
                            end else begin
                                r_qdo   <= {2'b00, w_nextByte[7], 1'b0};
                                r_shift <= {w_nextByte[6:0], 1'b0};
                            end
                            r_outCnt <= 3'd1;
                            if (r_byteCnt != 2'd3) r_byteCnt <= r_byteCnt + 2'd1;
                            if (w_isRead) begin
                                r_addr  <= w_addrInc;
                                r_memRd <= 1'b1;
                            end
                        end else if (w_isQuad) begin
                            r_qdo    <= r_shift[7:4];
                            r_shift  <= {r_shift[3:0], 4'h0};
                            r_outCnt <= 3'd0;
                        end else begin
                            r_qdo    <= {2'b00, r_shift[7], 1'b0};
                            r_shift  <= {r_shift[6:0], 1'b0};
                            r_outCnt <= r_outCnt + 3'd1;
                        end
                    end
                    default: ;
                endcase
                if (w_enterData) r_memRd <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder: drives SPI mode-0 transactions,
// models the backing memory, and scoreboards returned bytes and read addresses.
module tb_spi_flash_responder;

    logic clk = 1'b0;
    logic arst;

    spi_flash_responder_if #(.AWIDTH(16)) bus ();

    spi_flash_responder #(
        .AWIDTH(16), .JEDEC_ID(24'hEF4016), .STATUS(8'h00), .QDUMMY(6)
    ) dut (
        .clk(clk),
        .arst(arst),
        .bus(bus)
    );

    int         passCount   = 0;
    int         totalChecks = 0;
    int         rdCount     = 0;
    int         rdMark;
    logic [7:0] mem [0:65535];
    logic [7:0] expQ [$];
    logic [15:0] expAddrQ [$];
    logic [3:0] oeIdleBad;
    logic [3:0] smpQdo;
    logic [3:0] smpOe;

    always #5 clk = ~clk;

    // Backing memory: read data valid the clk after the strobe.
    always @(posedge clk) begin
        if (bus.mem_rd) bus.mem_data <= mem[bus.mem_addr];
    end

    // Read-strobe monitor: counts strobes and checks addresses against the scoreboard.
    always @(negedge clk) begin
        if (bus.mem_rd === 1'b1) begin
            rdCount++;
            if (expAddrQ.size() > 0) checkOutput("memAddr", 32'(bus.mem_addr), 32'(expAddrQ.pop_front()));
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        totalChecks++;
        assert (obs === exp) passCount++;
        else $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // One SPI clock: set pads, low phase, sample DUT, high phase, fall.
    task automatic spiClock(input logic [3:0] drv, output logic [3:0] q, output logic [3:0] o);
        bus.qdi = drv;
        repeat (3) @(posedge clk);
        #1;
        q = bus.qdo;
        o = bus.oe;
        bus.sclk = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bus.sclk = 1'b0;
    endtask

    // Drive n clocks of value bits (io0) or nibbles (io3..io0), MSB first.
    task automatic applyStimulus(input logic [63:0] val, input int n, input bit quad);
        logic [3:0] q, o;
        for (int i = 0; i < n; i++) begin
            if (quad) spiClock(val[4*(n-1-i) +: 4], q, o);
            else      spiClock({3'b000, val[n-1-i]}, q, o);
            if (o !== 4'h0) oeIdleBad = o;
        end
    endtask

    // Read n bytes and score each against the expected queue.
    task automatic readBytes(input int n, input bit quad);
        logic [3:0] q, o;
        logic [3:0] expOe;
        logic [3:0] oeSeen;
        logic [7:0] b;
        expOe  = quad ? 4'hF : 4'h2;
        oeSeen = expOe;
        for (int i = 0; i < n; i++) begin
            b = 8'h00;
            for (int k = 0; k < (quad ? 2 : 8); k++) begin
                spiClock(4'h0, q, o);
                if (o !== expOe) oeSeen = o;
                b = quad ? {b[3:0], q} : {b[6:0], q[1]};
            end
            checkOutput("dataByte", 32'(b), 32'(expQ.pop_front()));
        end
        checkOutput("dataOe", 32'(oeSeen), 32'(expOe));
    endtask

    task automatic csLow();
        bus.cs_n = 1'b0;
        oeIdleBad = 4'h0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic csHigh();
        bus.cs_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("csOeOff", 32'(bus.oe), 32'h0);
        checkOutput("csQdoOff", 32'(bus.qdo), 32'h0);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic checkAddrDone();
        checkOutput("addrQDrained", 32'(expAddrQ.size()), 32'h0);
        expAddrQ.delete();
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'((i * 7 + 3) ^ (i >> 8));
        mem[16'h0010] = 8'hA5;
        mem[16'h0011] = 8'h3C;
        mem[16'h0012] = 8'h7E;
        mem[16'hFFFF] = 8'h12;
        mem[16'h0000] = 8'h34;
        arst = 1'b1;
        bus.sclk = 1'b0;
        bus.cs_n = 1'b1;
        bus.qdi  = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rstOe", 32'(bus.oe), 32'h0);
        checkOutput("rstQdo", 32'(bus.qdo), 32'h0);
        checkOutput("rstMemRd", 32'(bus.mem_rd), 32'h0);
        checkOutput("rstMemAddr", 32'(bus.mem_addr), 32'h0);
        arst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        $display("[TB] JEDEC ID");
        csLow();
        applyStimulus(64'h9F, 8, 1'b0);
        checkOutput("idCmdOe", 32'(oeIdleBad), 32'h0);
        expQ.push_back(8'hEF); expQ.push_back(8'h40); expQ.push_back(8'h16); expQ.push_back(8'hFF);
        readBytes(4, 1'b0);
        csHigh();

        $display("[TB] 0x03 read at 0x10");
        for (int i = 0; i < 4; i++) expAddrQ.push_back(16'(16'h0010 + i));
        for (int i = 0; i < 3; i++) expQ.push_back(mem[16'h0010 + i]);
        csLow();
        applyStimulus(64'h03, 8, 1'b0);
        applyStimulus(64'h000010, 24, 1'b0);
        checkOutput("readHdrOe", 32'(oeIdleBad), 32'h0);
        readBytes(3, 1'b0);
        csHigh();
        checkAddrDone();

        $display("[TB] 0xEB quad I/O read with wrap");
        expAddrQ.push_back(16'hFFFF); expAddrQ.push_back(16'h0000);
        expQ.push_back(mem[16'hFFFF]); expQ.push_back(mem[16'h0000]);
        csLow();
        applyStimulus(64'hEB, 8, 1'b0);
        applyStimulus(64'h00FFFF, 6, 1'b1);
        applyStimulus(64'h0, 6, 1'b0);
        checkOutput("ebHdrOe", 32'(oeIdleBad), 32'h0);
        readBytes(2, 1'b1);
        csHigh();
        checkAddrDone();

        $display("[TB] 0x6B quad output read");
        for (int i = 0; i < 3; i++) begin
            expAddrQ.push_back(16'(16'h0100 + i));
            expQ.push_back(mem[16'h0100 + i]);
        end
        csLow();
        applyStimulus(64'h6B, 8, 1'b0);
        applyStimulus(64'h000100, 24, 1'b0);
        applyStimulus(64'h0, 8, 1'b0);
        checkOutput("qorDummyOe", 32'(oeIdleBad), 32'h0);
        readBytes(3, 1'b1);
        csHigh();
        checkAddrDone();

        $display("[TB] 0x0B fast read");
        expAddrQ.push_back(16'h0020); expAddrQ.push_back(16'h0021);
        expQ.push_back(mem[16'h0020]); expQ.push_back(mem[16'h0021]);
        csLow();
        applyStimulus(64'h0B, 8, 1'b0);
        applyStimulus(64'h000020, 24, 1'b0);
        applyStimulus(64'h0, 8, 1'b0);
        checkOutput("fastDummyOe", 32'(oeIdleBad), 32'h0);
        readBytes(2, 1'b0);
        csHigh();
        checkAddrDone();

        $display("[TB] unsupported opcode then status");
        rdMark = rdCount;
        csLow();
        applyStimulus(64'h02, 8, 1'b0);
        applyStimulus(64'h0, 40, 1'b0);
        checkOutput("ignoreOe", 32'(oeIdleBad), 32'h0);
        checkOutput("ignoreNoRead", 32'(rdCount), 32'(rdMark));
        csHigh();
        expQ.push_back(8'h00); expQ.push_back(8'h00);
        csLow();
        applyStimulus(64'h05, 8, 1'b0);
        readBytes(2, 1'b0);
        csHigh();

        $display("[TB] cs_n abort mid-byte");
        expAddrQ.push_back(16'h0040); expAddrQ.push_back(16'h0041); expAddrQ.push_back(16'h0042);
        expQ.push_back(mem[16'h0040]);
        csLow();
        applyStimulus(64'h03, 8, 1'b0);
        applyStimulus(64'h000040, 24, 1'b0);
        readBytes(1, 1'b0);
        for (int i = 0; i < 3; i++) spiClock(4'h0, smpQdo, smpOe);
        rdMark = rdCount;
        csHigh();
        repeat (20) @(posedge clk);
        #1;
        checkOutput("abortNoRead", 32'(rdCount), 32'(rdMark));
        checkAddrDone();

        $display("[TB] reset mid-transaction");
        csLow();
        applyStimulus(64'h03, 8, 1'b0);
        applyStimulus(64'h000080, 24, 1'b0);
        for (int i = 0; i < 10; i++) spiClock(4'h0, smpQdo, smpOe);
        arst = 1'b1;
        #1;
        checkOutput("arstOe", 32'(bus.oe), 32'h0);
        checkOutput("arstQdo", 32'(bus.qdo), 32'h0);
        checkOutput("arstMemRd", 32'(bus.mem_rd), 32'h0);
        checkOutput("arstMemAddr", 32'(bus.mem_addr), 32'h0);
        bus.cs_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        arst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        expQ.push_back(8'hEF); expQ.push_back(8'h40); expQ.push_back(8'h16);
        csLow();
        applyStimulus(64'h9F, 8, 1'b0);
        readBytes(3, 1'b0);
        csHigh();

        $display("%0d/%0d checks passed", passCount, totalChecks);
        $finish;
    end

endmodule
